// File: rtl/intt_seq_if.sv
// Stream bundle for intt_seq: NTT-domain coefficients in, time-domain coefficients out.
// Ports: in_valid/in_ready/in_data (sink side of the block), out_valid/out_ready/out_data.
// Modports: slave = the transform block, master = whoever feeds and drains it.
interface intt_seq_if #(
  parameter int N = 9
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/intt_seq.sv
// intt_seq: streaming inverse NTT over Z_Q. Loads D coefficients, runs (D/2)*LOGD
// radix-2 DIT butterflies on one shared multiplier, scales by D^-1, drains in natural order.
// Ports: clk, rst (sync, active-high), io (intt_seq_if.slave stream pair), busy (not in LOAD).
// Option INTT_BYPASS_SCALE_EN: when defined, the D^-1 scaling pass is skipped (unscaled output).
// Latency: 1 + (D/2)*LOGD + D cycles from last input beat to first out_valid (scaling enabled).
module intt_seq #(
  parameter int N     = 9,
  parameter int D     = 8,
  parameter int LOGD  = 3,
  parameter int Q     = 257,
  parameter int W_INV = 193,
  parameter int D_INV = 225
) (
  input  logic         clk,
  input  logic         rst,
  intt_seq_if.slave    io,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_SCALE   = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_t;

  localparam logic [N-1:0]    QN      = N'(Q);
  localparam logic [N:0]      QN1     = (N+1)'(Q);
  localparam logic [N-1:0]    D_INV_N = N'(D_INV);
  localparam logic [LOGD-1:0] CNT_MAX = LOGD'(D - 1);
  localparam logic [LOGD-1:0] BF_MAX  = LOGD'(D / 2 - 1);
  localparam logic [LOGD-1:0] LAST_ST = LOGD'(LOGD - 1);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Evaluated only with constant arguments, so the twiddle table folds to constants.
  function automatic logic [N-1:0] pow_mod(input int e);
    longint acc;
    acc = 1;
    for (int i = 0; i < e; i++) acc = (acc * longint'(W_INV)) % longint'(Q);
    return N'(acc);
  endfunction

  function automatic logic [LOGD-1:0] bitrev(input logic [LOGD-1:0] x);
    logic [LOGD-1:0] r;
    r = '0;
    for (int b = 0; b < LOGD; b++) r[b] = x[LOGD-1-b];
    return r;
  endfunction

  function automatic logic [N-1:0] mod_q(input logic [2*N-1:0] x);
    return N'(x % (2*N)'(Q));
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [LOGD-1:0] cnt_q, cnt_d;     // load index, scale index, output index
  logic [LOGD-1:0] stage_q, stage_d; // butterfly stage
  logic [LOGD-1:0] bf_q, bf_d;       // butterfly number within the stage
  logic [N-1:0]    mem_q [D];

  // Twiddle ROM: entry e holds W_INV^e mod Q.
  logic [N-1:0] tw_rom [D];
  for (genvar g = 0; g < D; g++) begin : g_tw
    localparam logic [N-1:0] TWV = pow_mod(g);
    assign tw_rom[g] = TWV;
  end

  // ---------------------------------------------------------------------------
  // Butterfly addressing
  // Butterfly b of stage s: m = b mod half, lo = (b - m)*2 + m, hi = lo + half.
  // Twiddle exponent (D/len)*m equals m << (LOGD-1-s).
  // ---------------------------------------------------------------------------
  logic [LOGD-1:0] half, m_idx, lo_idx, hi_idx, tw_idx;

  always_comb begin
    half   = LOGD'(1) << stage_q;
    m_idx  = bf_q & (half - LOGD'(1));
    lo_idx = ((bf_q & ~(half - LOGD'(1))) << 1) | m_idx;
    hi_idx = lo_idx | half;
    tw_idx = m_idx << (LAST_ST - stage_q);
  end

  // ---------------------------------------------------------------------------
  // Datapath: one multiplier shared between butterflies and scaling
  // ---------------------------------------------------------------------------
  logic [N-1:0]   mul_a, mul_b, mul_r;
  logic [2*N-1:0] prod;
  logic [N-1:0]   bf_u, bf_sum, bf_dif;
  logic [N:0]     sum_w, dif_w;
  logic [N-1:0]   in_red;

  always_comb begin
`ifdef INTT_BYPASS_SCALE_EN
    mul_a = mem_q[hi_idx];
    mul_b = tw_rom[tw_idx];
`else
    if (state_q == ST_SCALE) begin
      mul_a = mem_q[cnt_q];
      mul_b = D_INV_N;
    end else begin
      mul_a = mem_q[hi_idx];
      mul_b = tw_rom[tw_idx];
    end
`endif
    prod  = {{N{1'b0}}, mul_a} * {{N{1'b0}}, mul_b};
    mul_r = mod_q(prod);

    bf_u  = mem_q[lo_idx];
    sum_w = {1'b0, bf_u} + {1'b0, mul_r};
    bf_sum = (sum_w >= QN1) ? N'(sum_w - QN1) : N'(sum_w);
    // Borrow case: add Q first in N+1 bits so the intermediate cannot wrap.
    dif_w  = (bf_u >= mul_r) ? ({1'b0, bf_u} - {1'b0, mul_r})
                             : ({1'b0, bf_u} + QN1 - {1'b0, mul_r});
    bf_dif = N'(dif_w);

    // A 9-bit input is below 2Q, so a single conditional subtract fully reduces it.
    in_red = (io.in_data >= QN) ? (io.in_data - QN) : io.in_data;
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  logic load_we, bf_we, sc_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    bf_d    = bf_q;
    load_we = 1'b0;
    bf_we   = 1'b0;
    sc_we   = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        if (io.in_valid) begin
          load_we = 1'b1;
          cnt_d   = cnt_q + LOGD'(1);
          if (cnt_q == CNT_MAX) state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        bf_we = 1'b1;
        if (bf_q == BF_MAX) begin
          bf_d = '0;
          if (stage_q == LAST_ST) begin
            stage_d = '0;
`ifdef INTT_BYPASS_SCALE_EN
            state_d = ST_OUTPUT;
`else
            state_d = ST_SCALE;
`endif
          end else begin
            stage_d = stage_q + LOGD'(1);
          end
        end else begin
          bf_d = bf_q + LOGD'(1);
        end
      end
`ifndef INTT_BYPASS_SCALE_EN
      ST_SCALE: begin
        sc_we = 1'b1;
        cnt_d = cnt_q + LOGD'(1);
        if (cnt_q == CNT_MAX) state_d = ST_OUTPUT;
      end
`endif
      ST_OUTPUT: begin
        if (io.out_ready) begin
          cnt_d = cnt_q + LOGD'(1);
          if (cnt_q == CNT_MAX) state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      stage_q <= '0;
      bf_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      bf_q    <= bf_d;
    end
  end

  // Coefficient buffer has no reset; every LOAD rewrites all D entries.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_we) mem_q[bitrev(cnt_q)] <= in_red;
      if (bf_we) begin
        mem_q[lo_idx] <= bf_sum;
        mem_q[hi_idx] <= bf_dif;
      end
      if (sc_we) mem_q[cnt_q] <= mul_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from state so they hold steady while out_ready is low
  // ---------------------------------------------------------------------------
  assign io.in_ready  = (state_q == ST_LOAD);
  assign io.out_valid = (state_q == ST_OUTPUT);
  assign io.out_data  = (state_q == ST_OUTPUT) ? mem_q[cnt_q] : '0;
  assign busy         = (state_q != ST_LOAD);

endmodule
